// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encodings, access size
// codes and the I/D fairness decision.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  // Returns 1 when an arbitration with at least one request present picks I:
  // I wins alone, or when D has already starved it for starve_lim grants.
  function automatic logic mem_port_grant(
    input logic       i_req,
    input logic       d_req,
    input logic [2:0] starve_cnt,
    input logic [2:0] starve_lim
  );
    return i_req && (!d_req || (starve_cnt == starve_lim));
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch (I)
// and the memory-access stage (D); holds the request until dready_n and
// returns read data through registers.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] daddr,
  output logic        dreq,
  output logic        dwrite,
  output logic [1:0]  dsize,
  output logic [31:0] input_ddata,
  input  logic [31:0] output_ddata,
  input  logic        dready_n,
  input  logic        dbusy,
  output logic        keep_if,
  output logic        keep_mem
);
  import mem_port_arbiter_pkg::*;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       grant_any;
  logic       grant_i;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    grant_any = (state == ST_IDLE) && !dbusy && (i_req || d_req);
    grant_i   = grant_any && mem_port_grant(i_req, d_req, starve_cnt, STARVE_LIM);
  end

  // A stage stays frozen until the cycle its done pulse is visible.
  assign keep_if  = i_req & ~i_done;
  assign keep_mem = d_req & ~d_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      starve_cnt  <= '0;
      dreq        <= 1'b0;
      dwrite      <= 1'b0;
      daddr       <= '0;
      dsize       <= SIZE_BYTE;
      input_ddata <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;

      if (!i_req || grant_i)
        starve_cnt <= '0;
      else if (grant_any && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 3'd1;

      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            dreq <= 1'b1;
            if (grant_i) begin
              state       <= ST_BUSY_I;
              daddr       <= i_addr;
              dwrite      <= 1'b0;
              dsize       <= SIZE_WORD;
              input_ddata <= '0;
            end else begin
              state       <= ST_BUSY_D;
              daddr       <= d_addr;
              dwrite      <= d_write;
              dsize       <= d_size;
              input_ddata <= d_write ? d_wdata : '0;
            end
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if (!dready_n) begin
            state       <= ST_IDLE;
            dreq        <= 1'b0;
            dwrite      <= 1'b0;
            input_ddata <= '0;
            if (state == ST_BUSY_I) begin
              i_rdata <= output_ddata;
              i_done  <= 1'b1;
            end else begin
              if (!dwrite)
                d_rdata <= output_ddata;
              d_done <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          dreq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle model of the port rules is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] daddr;
  logic        dreq;
  logic        dwrite;
  logic [1:0]  dsize;
  logic [31:0] input_ddata;
  logic [31:0] output_ddata;
  logic        dready_n;
  logic        dbusy;
  logic        keep_if;
  logic        keep_mem;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .daddr(daddr), .dreq(dreq), .dwrite(dwrite), .dsize(dsize),
    .input_ddata(input_ddata), .output_ddata(output_ddata),
    .dready_n(dready_n), .dbusy(dbusy),
    .keep_if(keep_if), .keep_mem(keep_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (0 = idle, 1 = serving I, 2 = serving D)
  int          m_side;
  int          m_starve;
  logic        m_dreq, m_dwrite, m_id, m_dd, go_i;
  logic [31:0] m_daddr, m_wd, m_ir, m_dr;
  logic [1:0]  m_dsize;

  always @(posedge clk) begin
    if (rst) begin
      m_side = 0; m_starve = 0; m_dreq = 0; m_dwrite = 0; m_id = 0; m_dd = 0;
      m_daddr = 0; m_wd = 0; m_ir = 0; m_dr = 0; m_dsize = 0;
    end else begin
      m_id = 0;
      m_dd = 0;
      if (m_side == 0) begin
        if (!dbusy && (i_req || d_req)) begin
          go_i     = i_req && (!d_req || m_starve == int'(STARVE_MAX));
          m_side   = go_i ? 1 : 2;
          m_dreq   = 1;
          m_daddr  = go_i ? i_addr : d_addr;
          m_dwrite = go_i ? 1'b0 : d_write;
          m_dsize  = go_i ? 2'b10 : d_size;
          m_wd     = (!go_i && d_write) ? d_wdata : 32'h0;
          if (!i_req || go_i) m_starve = 0;
          else if (m_starve < int'(STARVE_MAX)) m_starve = m_starve + 1;
        end else if (!i_req) begin
          m_starve = 0;
        end
      end else begin
        if (!i_req) m_starve = 0;
        if (!dready_n) begin
          if (m_side == 1) begin
            m_ir = output_ddata;
            m_id = 1;
          end else begin
            if (!m_dwrite) m_dr = output_ddata;
            m_dd = 1;
          end
          m_side = 0; m_dreq = 0; m_dwrite = 0; m_wd = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and grant log
  bit          chk_en = 0;
  int          cyc = 0;
  int          ddone_cyc = -1;
  logic        prev_dreq = 0;
  logic [31:0] glog[$];
  int          gcyc[$];

  always @(negedge clk) begin
    cyc++;
    if (dreq && !prev_dreq) begin
      glog.push_back(daddr);
      gcyc.push_back(cyc);
    end
    prev_dreq = dreq;
    if (d_done) ddone_cyc = cyc;
    if (chk_en) begin
      check("dreq",        32'(dreq),     32'(m_dreq));
      check("daddr",       daddr,         m_daddr);
      check("dwrite",      32'(dwrite),   32'(m_dwrite));
      check("dsize",       32'(dsize),    32'(m_dsize));
      check("input_ddata", input_ddata,   m_wd);
      check("i_done",      32'(i_done),   32'(m_id));
      check("d_done",      32'(d_done),   32'(m_dd));
      check("i_rdata",     i_rdata,       m_ir);
      check("d_rdata",     d_rdata,       m_dr);
      check("keep_if",     32'(keep_if),  32'(i_req & ~m_id));
      check("keep_mem",    32'(keep_mem), 32'(d_req & ~m_dd));
      check("one_done",    32'(i_done & d_done), 32'h0);
    end
  end

  // ---------------- stimulus: requesters drop req on done, memory answers after wait_n
  bit          i_hold = 0, d_hold = 0, idle_rdy_low = 0;
  int          wait_n = 0, busy_n = 0;
  logic [31:0] mem_data;
  assign output_ddata = mem_data;

  task automatic tick();
    @(negedge clk);
    #1;
    if (i_done && !i_hold) i_req = 1'b0;
    if (d_done && !d_hold) d_req = 1'b0;
    if (dreq) begin
      busy_n++;
      dready_n = (busy_n > wait_n) ? 1'b0 : 1'b1;
    end else begin
      busy_n   = 0;
      dready_n = idle_rdy_low ? 1'b0 : 1'b1;
    end
  endtask

  task automatic wait_done(input bit side_i, input int budget, input string name);
    int k = 0;
    while (!(side_i ? i_done : d_done) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_done_in_time"}, 32'(side_i ? i_done : d_done), 32'h1);
  endtask

  int          cnt;
  logic [31:0] exp_log[6];

  initial begin
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_write = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; dready_n = 1; dbusy = 0; mem_data = 0;
    tick(); tick();
    chk_en = 1;
    check("rst_dreq",  32'(dreq), 32'h0);
    check("rst_daddr", daddr,     32'h0);
    check("rst_dsize", 32'(dsize), 32'h0);
    check("rst_rdata", i_rdata | d_rdata, 32'h0);

    // Lone fetch, answered in the first BUSY cycle.
    rst = 0; i_req = 1; i_addr = 32'h100; mem_data = 32'hCAFE0100; wait_n = 0;
    #1 check("fetch_keep_if_c0", 32'(keep_if), 32'h1);
    tick();
    check("fetch_dreq_c1",    32'(dreq), 32'h1);
    check("fetch_daddr_c1",   daddr,     32'h100);
    check("fetch_keep_if_c1", 32'(keep_if), 32'h1);
    tick();
    check("fetch_done_c2",  32'(i_done), 32'h1);
    check("fetch_rdata_c2", i_rdata,     32'hCAFE0100);
    tick();
    check("fetch_done_c3",  32'(i_done), 32'h0);

    // Half-word load to give d_rdata a known value.
    d_req = 1; d_write = 0; d_size = 2'b01; d_addr = 32'h3000; mem_data = 32'h12345678; wait_n = 1;
    wait_done(0, 20, "load");
    check("load_rdata", d_rdata, 32'h12345678);
    tick();

    // Store held through three wait cycles.
    d_req = 1; d_write = 1; d_size = 2'b00; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    mem_data = 32'h55555555; wait_n = 3; cnt = 0;
    for (int k = 0; k < 20 && !d_done; k++) begin
      tick();
      if (dreq && dwrite && input_ddata == 32'hDEADBEEF) cnt++;
    end
    check("store_busy_cycles", 32'(cnt), 32'd4);
    check("store_done",        32'(d_done), 32'h1);
    check("store_rdata_kept",  d_rdata, 32'h12345678);
    check("store_idle_daddr",  daddr, 32'h2000);
    check("store_idle_wdata",  input_ddata, 32'h0);
    d_write = 0;
    tick();
    check("store_done_width", 32'(d_done), 32'h0);

    // Simultaneous requests: D first, I at the IDLE after d_done.
    glog.delete(); gcyc.delete();
    i_req = 1; i_addr = 32'h400; d_req = 1; d_addr = 32'h5000; d_size = 2'b10;
    mem_data = 32'h0BADF00D; wait_n = 1;
    wait_done(1, 30, "simul_i");
    check("simul_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("simul_first_d",  glog[0], 32'h5000);
      check("simul_second_i", glog[1], 32'h400);
      check("simul_i_after_ddone", 32'(gcyc[1]), 32'(ddone_cyc + 1));
    end
    tick();

    // Starvation: both held, D reissued continuously.
    glog.delete(); gcyc.delete();
    i_hold = 1; d_hold = 1; i_req = 1; d_req = 1; i_addr = 32'h800; d_addr = 32'h9000;
    mem_data = 32'h600DCAFE; wait_n = 0;
    for (int k = 0; k < 60 && glog.size() < 6; k++) tick();
    exp_log = '{32'h9000, 32'h9000, 32'h9000, 32'h9000, 32'h800, 32'h9000};
    check("starve_grants", 32'(glog.size()), 32'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++)
      check($sformatf("starve_grant%0d", k), glog[k], exp_log[k]);
    i_hold = 0; d_hold = 0;
    for (int k = 0; k < 40 && (i_req || d_req || dreq); k++) tick();
    check("starve_drained", 32'(i_req | d_req | dreq), 32'h0);

    // dbusy hold-off, with dready_n low while idle (must be ignored).
    dbusy = 1; idle_rdy_low = 1; d_req = 1; d_addr = 32'hA000; d_write = 0; wait_n = 2; cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (dreq || d_done) cnt++;
    end
    check("dbusy_no_req", 32'(cnt), 32'd0);
    dbusy = 0; idle_rdy_low = 0;
    tick();
    check("dbusy_grant_dreq",  32'(dreq), 32'h1);
    check("dbusy_grant_daddr", daddr, 32'hA000);
    dbusy = 1;  // raised mid-access: must not abort it
    wait_done(0, 20, "dbusy_busy");
    dbusy = 0;
    tick();

    // Reset in the middle of a D access.
    d_req = 1; d_addr = 32'h7000; wait_n = 10;
    for (int k = 0; k < 10 && !dreq; k++) tick();
    check("rstmid_dreq_before", 32'(dreq), 32'h1);
    rst = 1; d_req = 0;
    tick();
    check("rstmid_dreq",  32'(dreq), 32'h0);
    check("rstmid_ddone", 32'(d_done), 32'h0);
    check("rstmid_daddr", daddr, 32'h0);
    check("rstmid_rdata", i_rdata | d_rdata | input_ddata, 32'h0);
    rst = 0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
